// File: rtl/factorial.sv
// ---------------------------------------------------------------------------
// factorial
//
// Bus-attached factorial accelerator. A host programs it through a small
// slave register window. Once started, it takes a shared bus as master, pops
// N values one at a time from an input FIFO, computes N! (unsigned, truncated
// to 64 bits) and pushes each result to an output FIFO as three words:
// N, result[63:32], result[31:0]. When the input FIFO reads empty, the engine
// releases the bus, sets done and raises an interrupt if enabled.
//
// Ports
//   clk        : single clock, all state on the rising edge
//   reset_n    : asynchronous active-low reset
//   S_sel      : slave select
//   S_wr       : slave write (1) / read (0)
//   S_address  : slave register address
//   S_din      : slave write data
//   S_dout     : slave read data (combinational, 0 when not reading)
//   M_grant    : bus grant from the arbiter
//   M_din      : master read data
//   M_req      : bus request
//   M_wr       : master write strobe
//   M_address  : master address
//   M_dout     : master write data
//   interrupt  : done & INT_ENABLE
//
// Slave map : 0x00 STATUS {done,busy}, 0x01 INT_ENABLE, 0x02 INT_CLEAR,
//             0x03 OP_START, 0x04 RESULT_HI, 0x05 RESULT_LO
// Master map: 0x00 in-FIFO data, 0x01 in-FIFO flags,
//             0x10 out-FIFO data, 0x11 out-FIFO flags (bit5 full, bit4 empty)
// ---------------------------------------------------------------------------
module factorial (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        S_sel,
    input  logic        S_wr,
    input  logic [7:0]  S_address,
    input  logic [31:0] S_din,
    input  logic        M_grant,
    input  logic [31:0] M_din,
    output logic [31:0] S_dout,
    output logic        M_req,
    output logic        M_wr,
    output logic [7:0]  M_address,
    output logic [31:0] M_dout,
    output logic        interrupt
);

    // Slave register addresses
    localparam logic [7:0] REG_STATUS     = 8'h00;
    localparam logic [7:0] REG_INT_ENABLE = 8'h01;
    localparam logic [7:0] REG_INT_CLEAR  = 8'h02;
    localparam logic [7:0] REG_OP_START   = 8'h03;
    localparam logic [7:0] REG_RESULT_HI  = 8'h04;
    localparam logic [7:0] REG_RESULT_LO  = 8'h05;

    // Master bus addresses
    localparam logic [7:0] IN_DATA_ADDR   = 8'h00;
    localparam logic [7:0] IN_FLAG_ADDR_C = 8'h01;
    localparam logic [7:0] OUT_DATA_ADDR  = 8'h10;
    localparam logic [7:0] OUT_FLAG_ADDR_C = 8'h11;

    // Position of the empty bit in a FIFO flag word
    localparam int FLAG_EMPTY_BIT = 4;

    typedef enum logic [4:0] {
        IDLE,
        BUS_REQ,
        IN_FLAG_ADDR,
        IN_FLAG_CHK,
        N_ADDR,
        N_READ,
        MUL,
        SUB,
        BUS_REQ2,
        OUT_FLAG_ADDR,
        OUT_FLAG_CHK,
        WRITE2,
        WRITE1,
        WRITE0,
        RELEASE,
        DONE,
        INIT
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        int_en;
    logic        done;
    logic        start_req;
    logic [31:0] n_val;
    logic [31:0] counter;
    logic [63:0] result;
    logic [31:0] result_hi;
    logic [31:0] result_lo;

    logic        slave_wr;
    logic        slave_rd;
    logic        start_wr;
    logic        clear_wr;
    logic        busy;
    logic        latch_result;
    logic [63:0] final_result;

    // Only bit0 of the write data is meaningful for every writable register.
    logic        unused_din;
    assign unused_din = ^S_din[31:1];

    // Truncated 64x32 unsigned product; wrap-around for N > 20 is intended.
    function automatic logic [63:0] mul_trunc(input logic [63:0] a,
                                              input logic [31:0] b);
        return a * {32'd0, b};
    endfunction

    assign slave_wr = S_sel & S_wr;
    assign slave_rd = S_sel & ~S_wr;
    assign start_wr = slave_wr && (S_address == REG_OP_START) && S_din[0];
    assign clear_wr = slave_wr && (S_address == REG_INT_CLEAR) && done;

    assign busy      = (state != IDLE) && (state != DONE);
    assign interrupt = done & int_en;

    // A result is committed when compute finishes. N <= 1 skips the loop,
    // so the committed value is the initial product of 1.
    assign latch_result = (next_state == BUS_REQ2) &&
                          ((state == N_READ) || (state == SUB));
    assign final_result = (state == N_READ) ? 64'd1 : result;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and master bus outputs
    // -----------------------------------------------------------------------
    always_comb begin
        next_state = state;
        M_req      = 1'b0;
        M_wr       = 1'b0;
        M_address  = 8'h00;
        M_dout     = 32'h0;

        case (state)
            IDLE: begin
                // start_req is the registered OP_START strobe, so the request
                // appears one cycle after the write is sampled.
                if (start_req) next_state = BUS_REQ;
            end

            BUS_REQ: begin
                M_req = 1'b1;
                if (M_grant) next_state = IN_FLAG_ADDR;
            end

            IN_FLAG_ADDR: begin
                M_req     = 1'b1;
                M_address = IN_FLAG_ADDR_C;
                if (M_grant) next_state = IN_FLAG_CHK;
            end

            IN_FLAG_CHK: begin
                M_req = 1'b1;
                if (M_din[FLAG_EMPTY_BIT]) next_state = RELEASE;
                else                       next_state = N_ADDR;
            end

            N_ADDR: begin
                M_req     = 1'b1;
                M_address = IN_DATA_ADDR;
                if (M_grant) next_state = N_READ;
            end

            N_READ: begin
                M_req = 1'b1;
                if (M_din <= 32'd1) next_state = BUS_REQ2;
                else                next_state = MUL;
            end

            MUL: begin
                next_state = SUB;
            end

            SUB: begin
                // counter is decremented at this edge; stop once it reaches 1.
                if (counter <= 32'd2) next_state = BUS_REQ2;
                else                  next_state = MUL;
            end

            BUS_REQ2: begin
                M_req = 1'b1;
                if (M_grant) next_state = OUT_FLAG_ADDR;
            end

            OUT_FLAG_ADDR: begin
                M_req     = 1'b1;
                M_address = OUT_FLAG_ADDR_C;
                if (M_grant) next_state = OUT_FLAG_CHK;
            end

            OUT_FLAG_CHK: begin
                // Keep the bus and poll again until the output FIFO drains.
                M_req = 1'b1;
                if (M_din[FLAG_EMPTY_BIT]) next_state = WRITE2;
                else                       next_state = OUT_FLAG_ADDR;
            end

            WRITE2: begin
                M_req     = 1'b1;
                M_address = OUT_DATA_ADDR;
                M_dout    = n_val;
                M_wr      = 1'b1;
                if (M_grant) next_state = WRITE1;
            end

            WRITE1: begin
                M_req     = 1'b1;
                M_address = OUT_DATA_ADDR;
                M_dout    = result_hi;
                M_wr      = 1'b1;
                if (M_grant) next_state = WRITE0;
            end

            WRITE0: begin
                M_req     = 1'b1;
                M_address = OUT_DATA_ADDR;
                M_dout    = result_lo;
                M_wr      = 1'b1;
                if (M_grant) next_state = IN_FLAG_ADDR;
            end

            RELEASE: begin
                next_state = DONE;
            end

            DONE: begin
                if (clear_wr) next_state = INIT;
            end

            INIT: begin
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Host-visible control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_en    <= 1'b0;
            start_req <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (slave_wr && (S_address == REG_INT_ENABLE)) begin
                int_en <= S_din[0];
            end
            start_req <= start_wr && (state == IDLE);
            if (state == RELEASE) begin
                done <= 1'b1;
            end else if (state == INIT) begin
                done <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Compute datapath and result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_val     <= 32'h0;
            counter   <= 32'h0;
            result    <= 64'h0;
            result_hi <= 32'h0;
            result_lo <= 32'h0;
        end else begin
            case (state)
                N_READ: begin
                    n_val   <= M_din;
                    counter <= M_din;
                    result  <= 64'd1;
                end
                MUL: begin
                    result <= mul_trunc(result, counter);
                end
                SUB: begin
                    counter <= counter - 32'd1;
                end
                INIT: begin
                    n_val     <= 32'h0;
                    counter   <= 32'h0;
                    result    <= 64'h0;
                    result_hi <= 32'h0;
                    result_lo <= 32'h0;
                end
                default: begin
                end
            endcase

            if (latch_result) begin
                result_hi <= final_result[63:32];
                result_lo <= final_result[31:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Slave read mux
    // -----------------------------------------------------------------------
    always_comb begin
        S_dout = 32'h0;
        if (slave_rd) begin
            case (S_address)
                REG_STATUS:     S_dout = {30'h0, done, busy};
                REG_INT_ENABLE: S_dout = {31'h0, int_en};
                REG_INT_CLEAR:  S_dout = {31'h0, done};
                REG_RESULT_HI:  S_dout = result_hi;
                REG_RESULT_LO:  S_dout = result_lo;
                default:        S_dout = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_factorial.sv
module tb_factorial;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        S_sel = 1'b0;
    logic        S_wr = 1'b0;
    logic [7:0]  S_address = 8'h00;
    logic [31:0] S_din = 32'h0;
    logic        M_grant;
    logic [31:0] M_din;
    logic [31:0] S_dout;
    logic        M_req;
    logic        M_wr;
    logic [7:0]  M_address;
    logic [31:0] M_dout;
    logic        interrupt;

    logic        grant_en = 1'b1;

    int total = 0;
    int bad   = 0;

    factorial dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .S_sel     (S_sel),
        .S_wr      (S_wr),
        .S_address (S_address),
        .S_din     (S_din),
        .M_grant   (M_grant),
        .M_din     (M_din),
        .S_dout    (S_dout),
        .M_req     (M_req),
        .M_wr      (M_wr),
        .M_address (M_address),
        .M_dout    (M_dout),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    assign M_grant = M_req & grant_en;

    // ---------------- bus environment: arbiter + input/output FIFOs ----------
    logic [31:0] in_arr [0:255];
    int          in_wr = 0;           // owned by the stimulus process
    int          in_rd = 0;           // owned by the bus model
    logic [31:0] out_arr [0:1023];
    int          out_wr = 0;          // owned by the bus model
    int          out_chk = 0;         // owned by the stimulus process
    int          out_busy_until = 0;  // flag polls below this report non-empty
    int          out_flag_reads = 0;
    int          wr_at_last_poll = 0;
    int          wr_badaddr = 0;
    int          irq_cnt = 0;

    logic [31:0] rdata;
    logic [31:0] nxt;
    logic        flag_phase;
    logic        have_nxt;

    assign M_din = rdata;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata      <= 32'h0;
            nxt        <= 32'h0;
            flag_phase <= 1'b0;
            have_nxt   <= 1'b0;
        end else begin
            flag_phase <= 1'b0;
            // Data word becomes visible once the flag word has been consumed.
            if (flag_phase && have_nxt) begin
                rdata    <= nxt;
                have_nxt <= 1'b0;
            end
            if (M_req && M_grant && M_address == 8'h01) begin
                if (in_rd == in_wr) begin
                    rdata <= 32'h10;
                end else begin
                    rdata    <= 32'h20;
                    nxt      <= in_arr[in_rd[7:0]];
                    in_rd    <= in_rd + 1;
                    have_nxt <= 1'b1;
                end
                flag_phase <= 1'b1;
            end
            if (M_req && M_grant && M_address == 8'h11) begin
                rdata           <= (out_flag_reads < out_busy_until) ? 32'h00 : 32'h10;
                out_flag_reads  <= out_flag_reads + 1;
                wr_at_last_poll <= out_wr;
            end
            if (M_wr && M_grant) begin
                out_arr[out_wr[9:0]] <= M_dout;
                out_wr <= out_wr + 1;
                if (M_address != 8'h10) wr_badaddr <= wr_badaddr + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (interrupt) irq_cnt <= irq_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        S_sel = 1'b1; S_wr = 1'b1; S_address = a; S_din = d;
        @(negedge clk);
        S_sel = 1'b0; S_wr = 1'b0; S_address = 8'h00; S_din = 32'h0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        S_sel = 1'b1; S_wr = 1'b0; S_address = a;
        #1;
        d = S_dout;
        S_sel = 1'b0; S_address = 8'h00;
    endtask

    task automatic load(input logic [31:0] n);
        in_arr[in_wr[7:0]] = n;
        in_wr++;
    endtask

    task automatic wait_req(input logic lvl, input int budget, input string name);
        int n = 0;
        while (M_req !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, M_req, lvl);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        logic [31:0] s;
        rd(8'h00, s);
        while (!s[1] && n < budget) begin
            @(negedge clk);
            rd(8'h00, s);
            n++;
        end
        chk("done_set", s[1], 1);
    endtask

    task automatic chk_triple(input logic [31:0] n, input logic [63:0] f);
        if (out_wr - out_chk < 3) begin
            chk("out_words_present", out_wr - out_chk, 3);
            out_chk = out_wr;
            return;
        end
        chk("out_n",  out_arr[out_chk[9:0]], n);
        chk("out_hi", out_arr[(out_chk + 1) % 1024], f[63:32]);
        chk("out_lo", out_arr[(out_chk + 2) % 1024], f[31:0]);
        out_chk += 3;
    endtask

    task automatic chk_result_regs(input logic [63:0] f);
        logic [31:0] hi, lo;
        rd(8'h04, hi);
        rd(8'h05, lo);
        chk("result_hi_reg", hi, f[63:32]);
        chk("result_lo_reg", lo, f[31:0]);
    endtask

    task automatic clear_done();
        logic [31:0] s;
        wr(8'h02, 32'h0);
        repeat (2) @(negedge clk);
        rd(8'h00, s);
        chk("status_after_clear", s, 0);
        chk("irq_after_clear", interrupt, 0);
    endtask

    // Reference model: N! by plain 64-bit arithmetic.
    function automatic logic [63:0] fact(input logic [31:0] n);
        logic [63:0] f = 64'd1;
        for (longint i = 2; i <= longint'(n); i++) f = f * 64'(i);
        return f;
    endfunction

    typedef struct {
        logic [31:0] n;
        logic [63:0] f;
    } vec_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [7];
        logic [31:0] s;
        logic [31:0] rn [8];
        int          cnt;
        int          irq0;
        int          fr0;
        int          ow0;
        int          wr_seen;
        int          req_low;

        vecs[0] = '{32'd0,  64'd1};
        vecs[1] = '{32'd1,  64'd1};
        vecs[2] = '{32'd2,  64'd2};
        vecs[3] = '{32'd5,  64'd120};
        vecs[4] = '{32'd13, 64'h0000_0001_7328_CC00};
        vecs[5] = '{32'd20, 64'h21C3_677C_82B4_0000};
        vecs[6] = '{32'd21, 64'hC507_7D36_B8C4_0000};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_m_req", M_req, 0);
        chk("rst_irq", interrupt, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("m_req_idle", M_req, 0);
        chk("m_wr_idle", M_wr, 0);
        chk("m_addr_idle", M_address, 0);
        chk("m_dout_idle", M_dout, 0);
        rd(8'h00, s); chk("status_reset", s, 0);
        rd(8'h05, s); chk("result_lo_reset", s, 0);
        rd(8'h07, s); chk("unmapped_read", s, 0);

        // ---- N=10 walk-through with interrupt enabled ----
        wr(8'h01, 32'h1);
        rd(8'h01, s); chk("int_enable_rb", s, 1);
        load(32'd10);
        wr(8'h03, 32'h1);
        for (int i = 0; i < 2 && !M_req; i++) @(negedge clk);
        chk("req_after_start", M_req, 1);
        rd(8'h00, s); chk("status_busy", s[0], 1);
        wait_req(1'b0, 50, "req_drops_for_compute");
        cnt = 0;
        while (M_req == 1'b0 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("compute_cycles_n10", cnt, 18);
        wait_done(2000);
        chk("irq_raised", interrupt, 1);
        chk("req_released", M_req, 0);
        chk_triple(32'd10, 64'd3628800);
        chk_result_regs(64'd3628800);
        rd(8'h02, s); chk("int_clear_reads_done", s, 1);
        clear_done();

        // ---- table-driven single-value jobs ----
        foreach (vecs[i]) begin
            load(vecs[i].n);
            wr(8'h03, 32'h1);
            wait_done(2000);
            chk("vec_irq", interrupt, 1);
            chk_triple(vecs[i].n, vecs[i].f);
            chk_result_regs(vecs[i].f);
            clear_done();
        end

        // ---- interrupt disabled: done set, interrupt never asserted ----
        wr(8'h01, 32'h0);
        irq0 = irq_cnt;
        load(32'd3);
        wr(8'h03, 32'h1);
        wait_done(2000);
        repeat (3) @(negedge clk);
        chk("irq_disabled_count", irq_cnt - irq0, 0);
        chk_triple(32'd3, 64'd6);
        clear_done();
        wr(8'h01, 32'h1);

        // ---- grant withheld at BUS_REQ2, output FIFO busy for 3 polls ----
        ow0 = out_wr;
        fr0 = out_flag_reads;
        out_busy_until = out_flag_reads + 3;
        load(32'd7);
        wr(8'h03, 32'h1);
        wait_req(1'b0, 50, "req_drops_n7");
        grant_en = 1'b0;
        wait_req(1'b1, 50, "req_returns_n7");
        wr_seen = 0;
        req_low = 0;
        repeat (8) begin
            @(negedge clk);
            if (M_wr) wr_seen++;
            if (!M_req) req_low++;
        end
        chk("no_wr_without_grant", wr_seen, 0);
        chk("req_held_without_grant", req_low, 0);
        grant_en = 1'b1;
        wait_done(2000);
        chk("out_flag_polls", out_flag_reads - fr0, 4);
        chk("no_wr_during_polls", wr_at_last_poll, ow0);
        chk_triple(32'd7, 64'd5040);
        clear_done();

        // ---- randomized multi-value job against the reference model ----
        foreach (rn[i]) begin
            rn[i] = $urandom_range(0, 40);
            load(rn[i]);
        end
        wr(8'h03, 32'h1);
        wait_done(20000);
        chk("rand_irq", interrupt, 1);
        foreach (rn[i]) chk_triple(rn[i], fact(rn[i]));
        chk_result_regs(fact(rn[7]));
        chk("write_addresses", wr_badaddr, 0);
        clear_done();

        // ---- reset asserted mid-compute ----
        load(32'd30);
        wr(8'h03, 32'h1);
        wait_req(1'b0, 50, "req_drops_n30");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_m_req", M_req, 0);
        chk("midrst_m_wr", M_wr, 0);
        rd(8'h00, s); chk("midrst_status", s, 0);
        @(negedge clk);
        reset_n = 1'b1;
        in_wr = in_rd;
        out_chk = out_wr;
        @(negedge clk);
        rd(8'h01, s); chk("int_enable_after_rst", s, 0);
        load(32'd4);
        wr(8'h03, 32'h1);
        wait_done(2000);
        chk("irq_off_after_rst", interrupt, 0);
        chk_triple(32'd4, 64'd24);
        clear_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/factorial.md
# factorial

Bus-attached factorial accelerator with a 32-bit slave register port for host control and a 32-bit master port for reaching an input FIFO and an output FIFO on a shared arbitrated bus. Once started, it pops N values from the input FIFO and computes N! for each. Each result goes to the output FIFO as three words. When the input FIFO is found empty, it releases the bus and raises an interrupt if enabled.

## Interface
- No parameters.
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `S_sel` in 1: slave select.
- `S_wr` in 1: slave write (1) / read (0).
- `S_address` in 8: slave register address.
- `S_din` in 32: slave write data.
- `M_grant` in 1: bus grant from arbiter.
- `M_din` in 32: master read data.
- `S_dout` out 32: slave read data.
- `M_req` out 1: bus request.
- `M_wr` out 1: master write strobe.
- `M_address` out 8: master address.
- `M_dout` out 32: master write data.
- `interrupt` out 1: completion interrupt.

## Operation
Slave registers. A write takes effect when `S_sel & S_wr` is sampled. Reads are combinational: `S_dout` is the addressed value when `S_sel & ~S_wr`, otherwise 0.
- 0x00 STATUS (read-only): bit0 busy, bit1 done.
- 0x01 INT_ENABLE: bit0.
- 0x02 INT_CLEAR: any write while done triggers INIT. Reads return the done bit.
- 0x03 OP_START: writing bit0=1 in IDLE starts the engine. Ignored elsewhere.
- 0x04 RESULT_HI: last result[63:32], read-only.
- 0x05 RESULT_LO: last result[31:0], read-only.
- Writes to read-only or unmapped addresses are ignored. Reads of unmapped addresses return 0.

Master map:
- 0x00: input FIFO data (read pops).
- 0x01: input FIFO flags.
- 0x10: output FIFO data (write pushes).
- 0x11: output FIFO flags.
- Flag word bit5 = full, bit4 = empty.

State machine:
- IDLE: wait for OP_START, then go to BUS_REQ.
- BUS_REQ: `M_req`=1. On `M_grant` go to IN_FLAG_ADDR.
- IN_FLAG_ADDR → IN_FLAG_CHK: drive address 0x01, sample `M_din` in the next state.
  - Empty (bit4) → RELEASE.
  - Otherwise → N_ADDR.
- N_ADDR → N_READ: drive 0x00, latch `M_din` as N.
- N_READ → COMPUTE: drop `M_req`, set result = 1 and counter = N.
- COMPUTE loops MUL then SUB:
  - MUL: result = (result × counter)[63:0].
  - SUB: counter − 1.
  - Loop until counter ≤ 1. N=0 and N=1 give result 1.
- COMPUTE → BUS_REQ2: latch result into RESULT_HI/LO, `M_req`=1. On grant go to OUT_FLAG_ADDR → OUT_FLAG_CHK (address 0x11).
  - Not empty: re-poll while holding the bus.
  - Empty: WRITE2 → WRITE1 → WRITE0.
- WRITE2/WRITE1/WRITE0: one word each to 0x10 with `M_wr`=1.
  - WRITE2 writes N.
  - WRITE1 writes result[63:32].
  - WRITE0 writes result[31:0].
- After WRITE0: return to IN_FLAG_ADDR, keeping the bus.
- RELEASE: `M_req`=0, set done, go to DONE.
- DONE: wait for an INT_CLEAR write, then INIT.
- INIT: clear done, result registers and counters. INT_ENABLE is kept. Go to IDLE.

Rules:
- Bus-phase states (FLAG_ADDR, N_ADDR, WRITE*) advance only while `M_grant`=1. Otherwise they stall with `M_req` held.
- `interrupt` = done & INT_ENABLE.
- `M_wr`, `M_address`, `M_dout` are 0 outside master states.
- Arithmetic is unsigned 64-bit, truncated. N > 20 wraps modulo 2^64.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Registers 0.
- Start: an OP_START write sampled at edge t gives `M_req`=1 after edge t+1.
- Reads:
  - Address is driven for one cycle.
  - `M_din` is sampled at the end of the following cycle. The arbiter or FIFO must present the data by then.
- Writes are single-cycle: `M_wr`, `M_address`, `M_dout` are valid together.
- Compute latency is 2·max(N−1,0) cycles from N_READ to BUS_REQ2.
- `interrupt` rises the cycle after RELEASE and falls the cycle after the INT_CLEAR write.
- Reset asserted mid-operation returns immediately to IDLE with outputs 0.

## Test plan
- Reset, then INT_ENABLE=1 and OP_START=1 → `M_req`=1 within 2 cycles. `S_dout` at 0x00 reads busy.
- Grant, input flags 0x20, N=10 → `M_req` drops, 18 compute cycles, `M_req` returns. With output flags 0x10, writes go to 0x10 as 10, 0x0, 0x00375F00 (3628800).
- After those writes, input flags 0x10 → `M_req`=0 and `interrupt`=1. Write 0x02 with 0 → `interrupt`=0, IDLE, STATUS=0.
- N=0 and N=1 → result 1. N=20 → 0x21C3677C82B40000.
- INT_ENABLE=0 → full run completes with done=1 and `interrupt` held at 0.
- Grant withheld in BUS_REQ2 → no `M_wr` until grant. Output flags non-empty → repeated flag reads, no writes.
